// File: rtl/i4004_bus_master.sv
// Intel 4004-style instruction-cycle bus master: sequences the eight bus phases
// (A1..X3), drives the address, fetches the instruction, and runs WRR/RDR/SRC transfers.
module i4004_bus_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [11:0] pc_in,
  input  logic [3:0]  acc_in,
  input  logic [7:0]  src_in,
  input  logic [3:0]  dbus_in,
  output logic [3:0]  dbus_out,
  output logic        dbus_oe,
  output logic        sync,
  output logic        cm_rom,
  output logic [7:0]  instr,
  output logic        instr_valid,
  output logic [3:0]  rd_data,
  output logic        rd_valid,
  output logic [3:0]  phase
);

  typedef enum logic [3:0] {
    ST_A1   = 4'd0,
    ST_A2   = 4'd1,
    ST_A3   = 4'd2,
    ST_M1   = 4'd3,
    ST_M2   = 4'd4,
    ST_X1   = 4'd5,
    ST_X2   = 4'd6,
    ST_X3   = 4'd7,
    ST_IDLE = 4'd8
  } state_e;

  localparam logic [7:0] OP_WRR     = 8'hE2;
  localparam logic [7:0] OP_RDR     = 8'hEA;
  localparam logic [3:0] OPR_IO     = 4'hE;
  localparam logic [3:0] OPR_FIM_SRC = 4'h2;

  state_e      state_q, state_d;
  logic [11:0] pc_q;
  logic [3:0]  acc_q;
  logic [7:0]  src_q;
  logic [3:0]  opr_q;
  logic [7:0]  instr_q;
  logic [3:0]  rd_data_q;

  logic is_wrr, is_rdr, is_src;

  assign is_wrr = (instr_q == OP_WRR);
  assign is_rdr = (instr_q == OP_RDR);
  assign is_src = (instr_q[7:4] == OPR_FIM_SRC) && instr_q[0];

  // A new cycle may only start from IDLE or X3, so run is ignored anywhere else.
  assign sync = ((state_q == ST_IDLE) || (state_q == ST_X3)) && run && !rst;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: state_d = run ? ST_A1 : ST_IDLE;
      ST_A1:   state_d = ST_A2;
      ST_A2:   state_d = ST_A3;
      ST_A3:   state_d = ST_M1;
      ST_M1:   state_d = ST_M2;
      ST_M2:   state_d = ST_X1;
      ST_X1:   state_d = ST_X2;
      ST_X2:   state_d = ST_X3;
      ST_X3:   state_d = run ? ST_A1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      acc_q     <= '0;
      src_q     <= '0;
      opr_q     <= '0;
      instr_q   <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (sync) pc_q <= pc_in;
      case (state_q)
        ST_M1: opr_q <= dbus_in;
        ST_M2: instr_q <= {opr_q, dbus_in};
        ST_X1: begin
          acc_q <= acc_in;
          src_q <= src_in;
        end
        ST_X2: if (is_rdr) rd_data_q <= dbus_in;
        default: ;
      endcase
    end
  end

  always_comb begin
    dbus_oe  = 1'b0;
    dbus_out = 4'h0;
    cm_rom   = 1'b0;
    case (state_q)
      ST_A1: begin
        dbus_oe  = 1'b1;
        dbus_out = pc_q[3:0];
      end
      ST_A2: begin
        dbus_oe  = 1'b1;
        dbus_out = pc_q[7:4];
      end
      ST_A3: begin
        dbus_oe  = 1'b1;
        dbus_out = pc_q[11:8];
        cm_rom   = 1'b1;
      end
      // The full instruction is not yet known in M2, so the I/O check uses the captured OPR.
      ST_M2: cm_rom = (opr_q == OPR_IO);
      ST_X2: begin
        if (is_wrr) begin
          dbus_oe  = 1'b1;
          dbus_out = acc_q;
        end else if (is_src) begin
          dbus_oe  = 1'b1;
          dbus_out = src_q[7:4];
          cm_rom   = 1'b1;
        end
      end
      ST_X3: begin
        if (is_src) begin
          dbus_oe  = 1'b1;
          dbus_out = src_q[3:0];
        end
      end
      default: ;
    endcase
  end

  assign instr       = instr_q;
  assign instr_valid = (state_q == ST_X1);
  assign rd_data     = rd_data_q;
  assign rd_valid    = (state_q == ST_X3) && is_rdr;
  assign phase       = state_q;

endmodule

// File: tb/tb_i4004_bus_master.sv
// Self-checking bench for i4004_bus_master: the bench plays ROM/RAM responder and
// predicts each phase's bus activity from the instruction being executed.
module tb_i4004_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [11:0] pc_in;
  logic [3:0]  acc_in;
  logic [7:0]  src_in;
  logic [3:0]  dbus_in;
  logic [3:0]  dbus_out;
  logic        dbus_oe;
  logic        sync;
  logic        cm_rom;
  logic [7:0]  instr;
  logic        instr_valid;
  logic [3:0]  rd_data;
  logic        rd_valid;
  logic [3:0]  phase;

  int errors = 0;
  int checks = 0;

  // Reference state: last fetched instruction and last RDR result as seen from outside.
  logic [7:0] exp_instr;
  logic [3:0] exp_rd;

  i4004_bus_master dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .pc_in       (pc_in),
    .acc_in      (acc_in),
    .src_in      (src_in),
    .dbus_in     (dbus_in),
    .dbus_out    (dbus_out),
    .dbus_oe     (dbus_oe),
    .sync        (sync),
    .cm_rom      (cm_rom),
    .instr       (instr),
    .instr_valid (instr_valid),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .phase       (phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_sync);
    chk({tag, " phase"},       32'(phase),       32'd8);
    chk({tag, " sync"},        32'(sync),        32'(exp_sync));
    chk({tag, " dbus_oe"},     32'(dbus_oe),     32'd0);
    chk({tag, " dbus_out"},    32'(dbus_out),    32'd0);
    chk({tag, " cm_rom"},      32'(cm_rom),      32'd0);
    chk({tag, " instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, " rd_valid"},    32'(rd_valid),    32'd0);
    chk({tag, " instr"},       32'(instr),       32'(exp_instr));
    chk({tag, " rd_data"},     32'(rd_data),     32'(exp_rd));
  endtask

  // Called at the negedge of a clock in which the master should be in IDLE or X3 with run=1.
  // Runs one full instruction cycle; abort_at>=0 asserts rst after checking that phase.
  task automatic do_cycle(input logic [11:0] pc, input logic [7:0] code, input logic [3:0] acc,
                          input logic [7:0] src, input logic [3:0] rdv, input logic run_next,
                          input int abort_at);
    logic       e_oe, e_cm;
    logic [3:0] e_out;
    bit         wrr, rdr, srcop;
    string      t;
    wrr   = (code == 8'hE2);
    rdr   = (code == 8'hEA);
    srcop = (code[7:4] == 4'h2) && code[0];
    pc_in = pc;
    #1;
    chk("start sync", 32'(sync), 32'd1);
    for (int p = 0; p < 8; p++) begin
      @(negedge clk);
      pc_in   = 12'($urandom);
      acc_in  = (p == 5) ? acc : 4'($urandom);
      src_in  = (p == 5) ? src : 8'($urandom);
      dbus_in = (p == 3) ? code[7:4] : (p == 4) ? code[3:0] :
                (p == 6 && rdr) ? rdv : 4'($urandom);
      if (p == 7) run = run_next;
      else run = run_next ? 1'($urandom_range(0, 1)) : (p < 3);
      if (p == 5) exp_instr = code;
      if (p == 7 && rdr) exp_rd = rdv;
      e_oe = 1'b0; e_out = 4'h0; e_cm = 1'b0;
      case (p)
        0: begin e_oe = 1'b1; e_out = pc[3:0];  end
        1: begin e_oe = 1'b1; e_out = pc[7:4];  end
        2: begin e_oe = 1'b1; e_out = pc[11:8]; e_cm = 1'b1; end
        4: e_cm = (code[7:4] == 4'hE);
        6: begin
          if (wrr)        begin e_oe = 1'b1; e_out = acc; end
          else if (srcop) begin e_oe = 1'b1; e_out = src[7:4]; e_cm = 1'b1; end
        end
        7: if (srcop) begin e_oe = 1'b1; e_out = src[3:0]; end
        default: ;
      endcase
      #1;
      t = $sformatf("op%02h p%0d", code, p);
      chk({t, " phase"},       32'(phase),       32'(p));
      chk({t, " sync"},        32'(sync),        32'((p == 7) && run_next));
      chk({t, " dbus_oe"},     32'(dbus_oe),     32'(e_oe));
      chk({t, " dbus_out"},    32'(dbus_out),    32'(e_out));
      chk({t, " cm_rom"},      32'(cm_rom),      32'(e_cm));
      chk({t, " instr_valid"}, 32'(instr_valid), 32'(p == 5));
      chk({t, " rd_valid"},    32'(rd_valid),    32'((p == 7) && rdr));
      chk({t, " instr"},       32'(instr),       32'(exp_instr));
      chk({t, " rd_data"},     32'(rd_data),     32'(exp_rd));
      if (p == abort_at) begin
        rst = 1'b1;
        run = 1'b1;
        @(negedge clk);
        exp_instr = 8'h00;
        exp_rd    = 4'h0;
        #1;
        check_idle("abort", 1'b0);
        rst = 1'b0;
        return;
      end
    end
  endtask

  // Stays idle for n clocks with run low, then raises run so the next cycle can start.
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      run     = 1'b0;
      dbus_in = 4'($urandom);
      pc_in   = 12'($urandom);
      #1;
      check_idle("idle", 1'b0);
    end
    run = 1'b1;
  endtask

  initial begin
    logic [7:0] code;
    logic       rn;
    rst = 1'b1; run = 1'b1;
    pc_in = '0; acc_in = '0; src_in = '0; dbus_in = '0;
    exp_instr = 8'h00;
    exp_rd    = 4'h0;
    repeat (3) @(negedge clk);
    #1;
    check_idle("reset", 1'b0);
    rst = 1'b0;

    do_cycle(12'h3A5, 8'h5C, 4'($urandom), 8'($urandom), 4'($urandom), 1'b1, -1);
    do_cycle(12'($urandom), 8'hE2, 4'h9, 8'($urandom), 4'($urandom), 1'b1, -1);
    do_cycle(12'($urandom), 8'hEA, 4'($urandom), 8'($urandom), 4'h6, 1'b1, -1);
    do_cycle(12'($urandom), 8'h23, 4'($urandom), 8'hB4, 4'($urandom), 1'b0, -1);
    idle_gap(2);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       code = 8'hE2;
        1:       code = 8'hEA;
        2:       code = {4'h2, 3'($urandom), 1'b1};
        default: code = 8'($urandom);
      endcase
      rn = ($urandom_range(0, 4) != 0);
      do_cycle(12'($urandom), code, 4'($urandom), 8'($urandom), 4'($urandom), rn, -1);
      if (!rn) idle_gap($urandom_range(1, 3));
    end

    do_cycle(12'($urandom), 8'hE2, 4'h9, 8'($urandom), 4'($urandom), 1'b1, 6);
    do_cycle(12'h3A5, 8'h5C, 4'($urandom), 8'($urandom), 4'($urandom), 1'b0, -1);
    idle_gap(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i4004_bus_master.md
I4004_BUS_MASTER -- requirements
Module: i4004_bus_master

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port run, input, 1 bit: high at IDLE or X3 starts or continues instruction cycles.
REQ-004 SHALL have port pc_in, input, 12 bits: instruction address; sampled on any edge where sync=1.
REQ-005 SHALL have port acc_in, input, 4 bits: WRR write data; sampled at the end of X1.
REQ-006 SHALL have port src_in, input, 8 bits: SRC register-pair value; sampled at the end of X1.
REQ-007 SHALL have port dbus_in, input, 4 bits: bus data driven by ROM/RAM responders.
REQ-008 SHALL have port dbus_out, output, 4 bits: bus data driven by this master.
REQ-009 SHALL have port dbus_oe, output, 1 bit: high when dbus_out is valid and being driven.
REQ-010 SHALL have port sync, output, 1 bit: instruction-cycle marker; the phase after sync is A1.
REQ-011 SHALL have port cm_rom, output, 1 bit: ROM command line.
REQ-012 SHALL have port instr, output, 8 bits: fetched instruction {OPR,OPA}; held until the next fetch.
REQ-013 SHALL have port instr_valid, output, 1 bit: one-cycle pulse in X1.
REQ-014 SHALL have port rd_data, output, 4 bits: RDR read result; held until the next RDR.
REQ-015 SHALL have port rd_valid, output, 1 bit: one-cycle pulse in X3 after an RDR.
REQ-016 SHALL have port phase, output, 4 bits: current state encoding; IDLE=8, A1..X3=0..7.

Function
REQ-017 SHALL implement states IDLE, A1, A2, A3, M1, M2, X1, X2, X3 and advance one state per clk.
REQ-018 SHALL take these transitions: A1 through X3 in order; X3 to A1 if run=1, else to IDLE; IDLE to A1 if run=1.
REQ-019 SHALL drive sync=1 only in IDLE or X3 when run=1, and latch pc_in on that same edge.
REQ-020 SHALL decode all outputs combinationally from the current state and the latched registers.
REQ-021 SHALL drive dbus_oe=1 and dbus_out as pc[3:0] in A1, pc[7:4] in A2, and pc[11:8] in A3.
REQ-022 SHALL assert cm_rom in A3 of every cycle for bank select.
REQ-023 SHALL hold dbus_oe=0 in M1 and M2, capture OPR=dbus_in at the end of M1, and capture OPA=dbus_in at the end of M2.
REQ-024 SHALL assert cm_rom in M2 if the OPR captured in M1 equals 4'hE (I/O group).
REQ-025 SHALL update instr at the end of M2 and pulse instr_valid in the following X1.
REQ-026 SHALL, for WRR (instr=8'hE2), drive dbus_oe=1 with dbus_out=acc_in latched at X1 during X2.
REQ-027 SHALL, for RDR (instr=8'hEA), hold dbus_oe=0 in X2, latch rd_data=dbus_in at the end of X2, and pulse rd_valid in X3.
REQ-028 SHALL, for SRC (OPR=4'h2, OPA[0]=1), drive cm_rom=1, dbus_oe=1 and dbus_out=src[7:4] in X2.
REQ-029 SHALL, for SRC, drive dbus_oe=1 with dbus_out=src[3:0] and cm_rom=0 in X3.
REQ-030 SHALL treat all other instructions as having no X2/X3 bus activity: dbus_oe=0, cm_rom=0.
REQ-031 SHALL drive dbus_out=0 whenever dbus_oe=0.
REQ-032 SHALL let a deasserted run take effect only at X3; a cycle in progress always completes.
REQ-033 SHALL ignore pc_in, acc_in and src_in outside their sampling edges.
REQ-034 SHALL, with back-to-back cycles, hold sync=1 for exactly one clk per 8-clk cycle.

Reset
REQ-035 SHALL, while rst=1, force: state=IDLE, sync=0, cm_rom=0, dbus_oe=0, dbus_out=0, instr=0, instr_valid=0, rd_data=0, rd_valid=0, latched pc/acc/src=0.
REQ-036 SHALL give rst priority over run, and SHALL abort any in-progress cycle without a valid pulse.
REQ-037 SHALL enter A1 at the earliest 2 clks after rst deasserts with run=1: one IDLE/sync clk, then A1.

Verification
REQ-038 SHALL pass this fetch test: run=1, pc_in=12'h3A5, ROM returns 8'h5C -> dbus_out 5,A,3 in A1..A3; cm_rom high only in A3; instr=8'h5C with instr_valid at X1.
REQ-039 SHALL pass this WRR test: instr 8'hE2, acc_in=4'h9 -> cm_rom=1 in M2; X2 dbus_oe=1, dbus_out=4'h9.
REQ-040 SHALL pass this RDR test: instr 8'hEA, responder drives 4'h6 in X2 -> rd_data=4'h6 with rd_valid in X3; dbus_oe=0 in X2.
REQ-041 SHALL pass this SRC test: instr 8'h23, src_in=8'hB4 -> X2 cm_rom=1, dbus_out=4'hB; X3 cm_rom=0, dbus_out=4'h4.
REQ-042 SHALL pass this run-deassert test: run drops in M1 -> cycle completes, sync=0 in X3, state goes IDLE; run=1 again -> one sync clk, then A1.
REQ-043 SHALL pass this reset test: rst asserted in X2 of a WRR -> next clk IDLE, all outputs 0; no instr_valid or rd_valid.
